// File: rtl/ni_transmit_control_mc.sv
`default_nettype none
// =============================================================================
// Module  : ni_transmit_control_mc
// Brief   : Multi-channel credit-based NI transmit controller; round-robin
//           whole-packet arbitration with sticky per-channel tx_gone.
// Revision: 1.0
// =============================================================================

`ifndef COUNTERFLITWD
`define COUNTERFLITWD 4
`endif

module ni_transmit_control_mc #(
    parameter int NUM_CH      = 2,
    parameter int CH_W        = 1,
    parameter int CNT_W       = `COUNTERFLITWD,
    parameter int MAX_CREDITS = 4,
    parameter int CREDIT_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       send_message,
    input  logic [NUM_CH*CNT_W-1:0] num_flit_to_transmit,
    input  logic                    stall,
    input  logic [NUM_CH-1:0]       credit_in,
    input  logic                    last_clock_beat,
    output logic                    valid,
    output logic [CH_W-1:0]         flit_ch,
    output logic [CNT_W-1:0]        flit_counter,
    output logic                    head,
    output logic                    tail,
    output logic [NUM_CH-1:0]       tx_gone,
    output logic                    busy
);

    localparam logic [CREDIT_W-1:0] C_MAX_CREDIT = CREDIT_W'(MAX_CREDITS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_cur_ch;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W-1:0]     w_grant_ch;
    logic [CNT_W-1:0]    r_cur_len;
    logic [CNT_W-1:0]    r_flit_counter;
    logic [NUM_CH-1:0]   r_gone;
    logic [NUM_CH-1:0]   w_elig;
    logic [NUM_CH-1:0]   w_tail_bits;
    logic [NUM_CH-1:0]   w_credit_nz;
    logic                w_grant;
    logic                w_last_flit;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_elig
        assign w_elig[i] = send_message[i] & ~r_gone[i]
                         & (num_flit_to_transmit[i*CNT_W +: CNT_W] != '0);
    end

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        w_grant    = 1'b0;
        w_grant_ch = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!w_grant && w_elig[(int'(r_rr_ptr) + k) % NUM_CH]) begin
                w_grant    = 1'b1;
                w_grant_ch = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
            end
        end
    end

    assign w_last_flit  = (r_flit_counter == r_cur_len - CNT_W'(1));
    assign valid        = (r_state == ST_SEND) && !stall && w_credit_nz[r_cur_ch];
    assign head         = valid && (r_flit_counter == '0);
    assign tail         = valid && w_last_flit;
    assign w_tail_bits  = tail ? (NUM_CH'(1) << r_cur_ch) : '0;
    assign tx_gone      = r_gone | w_tail_bits;
    assign busy         = (r_state == ST_SEND);
    assign flit_ch      = r_cur_ch;
    assign flit_counter = r_flit_counter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant) w_state_nxt = ST_SEND;
            ST_SEND: if (tail)    w_state_nxt = ST_IDLE;
            default:              w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_ch       <= '0;
            r_cur_len      <= '0;
            r_flit_counter <= '0;
            r_rr_ptr       <= CH_W'(NUM_CH - 1);
            r_gone         <= '0;
        end else begin
            if (r_state == ST_IDLE && w_grant) begin
                r_cur_ch       <= w_grant_ch;
                r_cur_len      <= num_flit_to_transmit[int'(w_grant_ch)*CNT_W +: CNT_W];
                r_rr_ptr       <= w_grant_ch;
                r_flit_counter <= '0;
            end else if (valid) begin
                r_flit_counter <= w_last_flit ? '0 : r_flit_counter + CNT_W'(1);
            end
            // A tail on a last_clock_beat cycle is visible only combinationally.
            r_gone <= last_clock_beat ? '0 : (r_gone | w_tail_bits);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_credit
        logic [CREDIT_W-1:0] r_credit;
        logic                w_spend;

        assign w_spend        = valid && (r_cur_ch == CH_W'(i));
        assign w_credit_nz[i] = (r_credit != '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_credit <= C_MAX_CREDIT;
            end else if (w_spend && !credit_in[i]) begin
                r_credit <= r_credit - CREDIT_W'(1);
            end else if (!w_spend && credit_in[i] && r_credit != C_MAX_CREDIT) begin
                r_credit <= r_credit + CREDIT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire
